// File: rtl/neuron_mac.sv
// neuron_mac: multiply-accumulate stage for one neuron.
// Accepts INPUT_MAX activation/weight beats plus one bias beat over a
// valid/ready handshake, accumulates at full precision, then rescales,
// saturates and holds one WORD_SIZE result behind a valid/ready output.
// Optional build macro: NEURON_MAC_RELU_EN clamps negative results to 0.
module neuron_mac #(
    parameter int WORD_SIZE = 16,
    parameter int N_SIZE    = 8,
    parameter int INPUT_MAX = 10
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             start_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [WORD_SIZE-1:0]             data_i,
    input  logic [WORD_SIZE-1:0]             weight_i,
    output logic [$clog2(INPUT_MAX+1)-1:0]   weight_addr_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [WORD_SIZE-1:0]             data_o
);

    localparam int AW    = $clog2(INPUT_MAX + 1);
    localparam int PW    = 2 * WORD_SIZE;
    // Headroom for INPUT_MAX full-scale products plus the bias term.
    localparam int ACC_W = PW + $clog2(INPUT_MAX + 2);

    localparam logic [AW-1:0] LAST_IDX = AW'(INPUT_MAX);

    localparam logic [1:0] eIDLE  = 2'd0;
    localparam logic [1:0] eACCUM = 2'd1;
    localparam logic [1:0] eDONE  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    // Clamp a rescaled accumulator value into the signed word range.
    function automatic logic signed [WORD_SIZE-1:0] saturate(
        input logic signed [ACC_W-1:0] v
    );
        if (v > SAT_MAX)
            return SAT_MAX[WORD_SIZE-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[WORD_SIZE-1:0];
        else
            return v[WORD_SIZE-1:0];
    endfunction

    // Final activation applied to the saturated word.
    function automatic logic signed [WORD_SIZE-1:0] activate(
        input logic signed [WORD_SIZE-1:0] v
    );
`ifdef NEURON_MAC_RELU_EN
        if (v[WORD_SIZE-1])
            return '0;
        else
            return v;
`else
        return v;
`endif
    endfunction

    logic [1:0]                     state_q, state_d;
    logic [AW-1:0]                  count_q, count_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic                           valid_q, valid_d;
    logic signed [WORD_SIZE-1:0]    data_q, data_d;

    logic signed [WORD_SIZE-1:0]    act_s;
    logic signed [WORD_SIZE-1:0]    wgt_s;
    logic signed [PW-1:0]           prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        bias_ext;
    logic signed [ACC_W-1:0]        acc_total;
    logic signed [ACC_W-1:0]        acc_scaled;

    assign act_s      = data_i;
    assign wgt_s      = weight_i;
    assign prod       = act_s * wgt_s;
    assign prod_ext   = {{(ACC_W-PW){prod[PW-1]}}, prod};
    // Bias is a Q-format word; align it to the product's 2*N_SIZE fraction.
    assign bias_ext   = {{(ACC_W-WORD_SIZE){wgt_s[WORD_SIZE-1]}}, wgt_s} <<< N_SIZE;
    assign acc_total  = acc_q + bias_ext;
    // Arithmetic shift truncates toward minus infinity.
    assign acc_scaled = acc_total >>> N_SIZE;

    // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        data_d  = data_q;
        case (state_q)
            eIDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = eACCUM;
                end
            end
            eACCUM: begin
                if (valid_i) begin
                    if (count_q == LAST_IDX) begin
                        acc_d   = acc_total;
                        data_d  = activate(saturate(acc_scaled));
                        valid_d = 1'b1;
                        count_d = '0;
                        state_d = eDONE;
                    end else begin
                        acc_d   = acc_q + prod_ext;
                        count_d = count_q + 1'b1;
                    end
                end
            end
            eDONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = eIDLE;
                end
            end
            default: begin
                state_d = eIDLE;
                count_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any partial sum immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eIDLE;
            count_q <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready_o       = (state_q == eACCUM);
    assign weight_addr_o = count_q;
    assign valid_o       = valid_q;
    assign data_o        = data_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed vectors for neuron_mac with INPUT_MAX=3.
// Weight/data memories are modelled combinationally from weight_addr_o.
module tb_neuron_mac;

    localparam int WS = 16;
    localparam int NS = 8;
    localparam int IM = 3;
    localparam int AW = $clog2(IM + 1);

    logic               clk;
    logic               reset_n;
    logic               start;
    logic               valid_in;
    logic               ready_out;
    logic [WS-1:0]      data_in;
    logic [WS-1:0]      weight_in;
    logic [AW-1:0]      waddr;
    logic               valid_out;
    logic               ready_in;
    logic [WS-1:0]      data_out;

    logic signed [WS-1:0] dmem [0:IM];
    logic signed [WS-1:0] wmem [0:IM];

    int n_cmp;
    int n_err;
    int cyc;

    typedef struct {
        string               name;
        logic signed [WS-1:0] d0, d1, d2;
        logic signed [WS-1:0] w0, w1, w2;
        logic signed [WS-1:0] bias;
        int                  expect_raw;
    } vec_t;

    vec_t vecs [8];

    neuron_mac #(.WORD_SIZE(WS), .N_SIZE(NS), .INPUT_MAX(IM)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .start_i      (start),
        .valid_i      (valid_in),
        .ready_o      (ready_out),
        .data_i       (data_in),
        .weight_i     (weight_in),
        .weight_addr_o(waddr),
        .valid_o      (valid_out),
        .ready_i      (ready_in),
        .data_o       (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        data_in   = dmem[waddr];
        weight_in = wmem[waddr];
    end

    function automatic int expect_out(input int raw);
`ifdef NEURON_MAC_RELU_EN
        return (raw < 0) ? 0 : raw;
`else
        return raw;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input vec_t v);
        dmem[0] = v.d0; dmem[1] = v.d1; dmem[2] = v.d2; dmem[3] = 16'sh1234;
        wmem[0] = v.w0; wmem[1] = v.w1; wmem[2] = v.w2; wmem[3] = v.bias;
    endtask

    // Start a run and feed all beats; returns with the DUT expected in eDONE.
    task automatic feed(input string name, input int gap);
        cyc      = 0;
        start    = 1'b1;
        valid_in = (gap == 0);
        tick();
        start = 1'b0;
        check({name, "_ready"}, int'(ready_out), 1);
        for (int b = 0; b <= IM; b++) begin
            valid_in = 1'b1;
            check({name, "_addr"}, int'(waddr), b);
            if (b == IM)
                check({name, "_vld_pre"}, int'(valid_out), 0);
            tick();
            if (b < IM && gap > 0) begin
                valid_in = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check({name, "_gap_addr"}, int'(waddr), b + 1);
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (valid_out && t < 10) begin
            tick();
            t++;
        end
        check({name, "_vld_drop"}, int'(valid_out), 0);
        check({name, "_idle_addr"}, int'(waddr), 0);
    endtask

    task automatic run_vec(input vec_t v, input int gap);
        load(v);
        feed(v.name, gap);
        check({v.name, "_valid"}, int'(valid_out), 1);
        check({v.name, "_data"}, int'($signed(data_out)), expect_out(v.expect_raw));
        if (gap == 0)
            check({v.name, "_lat"}, cyc, IM + 2);
        wait_idle(v.name);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        start    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i <= IM; i++) begin
            dmem[i] = '0;
            wmem[i] = '0;
        end

        vecs[0] = '{"basic",   16'sd256,  16'sd512,  -16'sd256, 16'sd256, 16'sd256, 16'sd256, 16'sd128, 640};
        vecs[1] = '{"sat_pos", 16'sh7F00, 16'sh7F00, 16'sh7F00, 16'sh7F00, 16'sh7F00, 16'sh7F00, 16'sd0, 32767};
        vecs[2] = '{"sat_neg", 16'sh7F00, 16'sh7F00, 16'sh7F00, 16'sh8100, 16'sh8100, 16'sh8100, 16'sd0, -32768};
        vecs[3] = '{"trunc_neg", -16'sd1, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd0, -1};
        vecs[4] = '{"trunc_pos", 16'sd1, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 0};
        vecs[5] = '{"neg_mix", -16'sd256, -16'sd256, 16'sd0, 16'sd256, 16'sd256, 16'sd256, 16'sd256, -256};
        vecs[6] = '{"edge_max", 16'sh7FFF, 16'sd0, 16'sd0, 16'sd256, 16'sd0, 16'sd0, 16'sd0, 32767};
        vecs[7] = '{"bias_min", 16'sd5, 16'sd7, 16'sd9, 16'sd0, 16'sd0, 16'sd0, 16'sh8000, -32768};

        // Reset state
        reset_n = 1'b0;
        #12;
        check("rst_valid", int'(valid_out), 0);
        check("rst_ready", int'(ready_out), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_addr", int'(waddr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Idle without start stays idle
        tick();
        check("idle_hold", int'(ready_out), 0);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], 0);

        // valid_i gaps of two cycles between beats
        vecs[0].name = "gaps";
        run_vec(vecs[0], 2);

        // Backpressure in eDONE with a start pulse that must be ignored
        load(vecs[0]);
        ready_in = 1'b0;
        feed("bp", 0);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            check("bp_valid", int'(valid_out), 1);
            check("bp_data", int'($signed(data_out)), 640);
            tick();
        end
        start    = 1'b0;
        ready_in = 1'b1;
        tick();
        check("bp_release_valid", int'(valid_out), 0);
        check("bp_release_idle", int'(ready_out), 0);
        check("bp_data_hold", int'($signed(data_out)), 640);
        tick();
        check("bp_start_ignored", int'(ready_out), 0);

        // Asynchronous reset after beat 1 (data_o holds 640 beforehand)
        load(vecs[1]);
        start    = 1'b1;
        valid_in = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_addr", int'(waddr), 2);
        #3;
        reset_n  = 1'b0;
        valid_in = 1'b0;
        #1;
        check("arst_data", int'(data_out), 0);
        check("arst_addr", int'(waddr), 0);
        check("arst_ready", int'(ready_out), 0);
        check("arst_valid", int'(valid_out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        vecs[0].name = "post_rst";
        run_vec(vecs[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
